// File: rtl/multi_instance_sched.sv
// multi_instance_sched
//   Launches a set of instance channels for a number of rounds. Each round
//   pulses start_inst on the enabled channels, skips one settle cycle, then
//   waits until every enabled channel has reported inst_ready. A per-round
//   timeout and an external abort both end the run with err set.
// Ports
//   clk, rst            clock, async active-high reset
//   start, abort        run request (sampled in IDLE) / cancel
//   ch_mask, rounds,    run configuration, latched when a run is accepted
//   tmo_limit
//   inst_ready          per-channel ready level from the instances
//   start_inst          one-cycle launch pulse per enabled channel
//   ready, busy, done   IDLE / LAUNCH-SETTLE-WAIT / completion pulse
//   err, tmo_mask       sticky failure flag / channels missing at timeout
//   round_idx, ch_done  current round (0-based) / per-channel done this round
module multi_instance_sched #(
    parameter int N_CH    = 4,
    parameter int ROUND_W = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [ROUND_W-1:0] rounds,
    input  logic [TMO_W-1:0]   tmo_limit,
    input  logic [N_CH-1:0]    inst_ready,
    output logic [N_CH-1:0]    start_inst,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [N_CH-1:0]    tmo_mask,
    output logic [ROUND_W-1:0] round_idx,
    output logic [N_CH-1:0]    ch_done
);

    typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, WAIT, FIN} state_t;

    state_t             state, state_nxt;
    logic [N_CH-1:0]    mask_q;
    logic [ROUND_W-1:0] rounds_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   cnt_cur;
    logic [N_CH-1:0]    done_cond;
    logic               all_done;
    logic               last_round;
    logic               timeout;
    logic               accept;

    // Ready levels seen this cycle count immediately, so a round can finish
    // in the same cycle its last channel reports.
    assign done_cond  = ch_done | (inst_ready & mask_q);
    assign all_done   = (done_cond & mask_q) == mask_q;
    // rounds==0 runs a single round
    assign last_round = (rounds_q == '0) ? (round_idx == '0)
                                         : (round_idx == rounds_q - 1'b1);
    // Count value including the current WAIT cycle (first WAIT cycle is 1).
    assign cnt_cur    = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
    // Completion takes priority over a coincident timeout.
    assign timeout    = (tmo_q != '0) && (cnt_cur == tmo_q) && !all_done;
    assign accept     = (state == IDLE) && start && !abort;

    assign start_inst = (state == LAUNCH) ? mask_q : '0;
    assign ready      = (state == IDLE);
    assign busy       = (state == LAUNCH) || (state == SETTLE) || (state == WAIT);
    assign done       = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (ch_mask == '0) ? FIN : LAUNCH;
            LAUNCH:  state_nxt = abort ? IDLE : SETTLE;
            SETTLE:  state_nxt = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)         state_nxt = IDLE;
                else if (all_done) state_nxt = last_round ? FIN : LAUNCH;
                else if (timeout)  state_nxt = IDLE;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            rounds_q  <= '0;
            tmo_q     <= '0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            tmo_mask  <= '0;
            round_idx <= '0;
            ch_done   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mask_q    <= ch_mask;
                    rounds_q  <= rounds;
                    tmo_q     <= tmo_limit;
                    err       <= 1'b0;
                    tmo_mask  <= '0;
                    round_idx <= '0;
                    ch_done   <= '0;
                end
                LAUNCH: begin
                    ch_done <= '0;
                    tmo_cnt <= '0;
                    if (abort) err <= 1'b1;
                end
                SETTLE: if (abort) err <= 1'b1;
                WAIT: begin
                    ch_done <= done_cond;
                    tmo_cnt <= cnt_cur;
                    if (abort) begin
                        err <= 1'b1;
                    end else if (all_done) begin
                        if (!last_round) round_idx <= round_idx + 1'b1;
                    end else if (timeout) begin
                        err      <= 1'b1;
                        tmo_mask <= mask_q & ~done_cond;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_instance_sched.sv
// Directed bench for multi_instance_sched. A behavioural instance model drives
// inst_ready with a per-channel delay after each launch; expected launch and
// done events go into a queue and are popped by a monitor on the falling edge.
module tb_multi_instance_sched;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [3:0]  ch_mask;
    logic [7:0]  rounds;
    logic [15:0] tmo_limit;
    logic [3:0]  inst_ready;
    logic [3:0]  start_inst, tmo_mask, ch_done;
    logic        ready, busy, done, err;
    logic [7:0]  round_idx;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] m;
        logic [7:0] r;
    } ev_t;
    ev_t exp_q[$];

    int dly[4];
    bit never[4];
    int cnt[4];

    multi_instance_sched #(.N_CH(4), .ROUND_W(8), .TMO_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_mask(ch_mask), .rounds(rounds), .tmo_limit(tmo_limit),
        .inst_ready(inst_ready), .start_inst(start_inst), .ready(ready),
        .busy(busy), .done(done), .err(err), .tmo_mask(tmo_mask),
        .round_idx(round_idx), .ch_done(ch_done)
    );

    always #5 clk = ~clk;

    // Instance model: a launch drops ready, which returns dly cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_ready <= 4'hF;
            for (int i = 0; i < 4; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (start_inst[i]) begin
                    if (never[i])        begin inst_ready[i] <= 1'b0; cnt[i] <= 0; end
                    else if (dly[i] == 0) inst_ready[i] <= 1'b1;
                    else                 begin inst_ready[i] <= 1'b0; cnt[i] <= dly[i]; end
                end else if (cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) inst_ready[i] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (start_inst != 4'h0 || done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {27'd0, done, start_inst}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.is_done) begin
                    chk("done_event", {31'd0, done}, 32'd1);
                    chk("done_err", {31'd0, err}, 32'd0);
                end else begin
                    chk("launch_mask", {28'd0, start_inst}, {28'd0, e.m});
                    chk("launch_round", {24'd0, round_idx}, {24'd0, e.r});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_launch(input logic [3:0] m, input logic [7:0] r);
        ev_t e;
        e.is_done = 1'b0; e.m = m; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1; e.m = 4'h0; e.r = 8'h0;
        exp_q.push_back(e);
    endtask

    task automatic go(input logic [3:0] m, input logic [7:0] r, input logic [15:0] t);
        ch_mask = m; rounds = r; tmo_limit = t; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ch_mask = 4'h0; rounds = 8'd0; tmo_limit = 16'd0;
        set_dly(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) never[i] = 1'b0;
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {done, err, tmo_mask, round_idx, ch_done, start_inst}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // single round, three channels, ready two cycles after launch
        set_dly(2, 2, 2, 2);
        push_launch(4'b1011, 8'd0); push_done();
        go(4'b1011, 8'd1, 16'd0);
        chk("t1_latency", {28'd0, start_inst}, 32'hB);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        chk("t1_ch_done", {28'd0, ch_done}, 32'hB);
        chk("t1_err", {31'd0, err}, 32'd0);
        tick();
        chk("t1_idle", {30'd0, ready, done}, 32'h2);

        // instant ready: LAUNCH, SETTLE, WAIT, then FIN
        set_dly(0, 0, 0, 0);
        push_launch(4'b1111, 8'd0); push_done();
        go(4'b1111, 8'd1, 16'd0);
        tick(); tick();
        chk("t2_wait_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("t2_fin_done", {31'd0, done}, 32'd1);
        tick();
        chk("t2_ready", {31'd0, ready}, 32'd1);

        // three rounds, staggered ready; config changes mid-run are ignored
        set_dly(1, 2, 3, 4);
        push_launch(4'hF, 8'd0); push_launch(4'hF, 8'd1); push_launch(4'hF, 8'd2); push_done();
        go(4'hF, 8'd3, 16'd0);
        ch_mask = 4'b0001; rounds = 8'd1; tmo_limit = 16'd1;
        wait_done(100);
        chk("t3_round_idx", {24'd0, round_idx}, 32'd2);
        tick();

        // timeout after the fifth WAIT cycle, ch2 never ready
        set_dly(0, 1, 0, 0); never[2] = 1'b1;
        push_launch(4'b0110, 8'd0);
        go(4'b0110, 8'd1, 16'd5);
        repeat (6) tick();
        chk("t4_busy_wait5", {30'd0, busy, err}, 32'h2);
        tick();
        chk("t4_ready", {31'd0, ready}, 32'd1);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_tmo_mask", {28'd0, tmo_mask}, 32'h4);
        never[2] = 1'b0;
        tick();

        // abort during WAIT of round 1 of 4
        set_dly(3, 3, 3, 3);
        push_launch(4'hF, 8'd0); push_launch(4'hF, 8'd1);
        go(4'hF, 8'd4, 16'd0);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            tick();
            if (start_inst != 4'h0 && round_idx == 8'd1) hit = 1'b1;
        end
        chk("t5_round1_launch", {31'd0, hit}, 32'd1);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_ready", {31'd0, ready}, 32'd1);
        chk("t5_abort_err", {31'd0, err}, 32'd1);
        chk("t5_abort_tmo_mask", {28'd0, tmo_mask}, 32'h0);

        // empty mask: straight to FIN; start clears err
        push_done();
        go(4'h0, 8'd5, 16'd0);
        chk("t6_err_cleared", {31'd0, err}, 32'd0);
        chk("t6_done_now", {27'd0, done, start_inst}, 32'h10);
        tick();
        chk("t6_ready", {30'd0, ready, done}, 32'h2);

        // rounds=0 runs once
        set_dly(1, 1, 1, 1);
        push_launch(4'b0101, 8'd0); push_done();
        go(4'b0101, 8'd0, 16'd0);
        wait_done(20);
        chk("t7_round_idx", {24'd0, round_idx}, 32'd0);
        tick();

        // reset during SETTLE discards the run
        set_dly(2, 2, 2, 2);
        push_launch(4'hF, 8'd0);
        go(4'hF, 8'd2, 16'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("t8_rst_ready", {30'd0, ready, busy}, 32'h2);
        chk("t8_rst_outs", {done, err, tmo_mask, round_idx, ch_done, start_inst}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        push_launch(4'b1001, 8'd0); push_done();
        go(4'b1001, 8'd1, 16'd0);
        wait_done(20);
        tick();

        // abort in IDLE blocks start
        ch_mask = 4'hF; rounds = 8'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t9_idle_abort", {27'd0, ready, start_inst}, 32'h10);
        repeat (3) tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multi_instance_sched.md
MULTI_INSTANCE_SCHED -- requirements
Module: multi_instance_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of controlled instance channels (1..32).
REQ-002 SHALL have parameter ROUND_W, default 8, width of round-count input and round index.
REQ-003 SHALL have parameter TMO_W, default 16, width of per-round timeout limit.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  cancel the run in progress.
REQ-008 SHALL have port ch_mask  input  N_CH  channels enabled for the run; latched on accept.
REQ-009 SHALL have port rounds  input  ROUND_W  number of launch rounds; latched on accept; 0 treated as 1.
REQ-010 SHALL have port tmo_limit  input  TMO_W  max WAIT cycles per round; latched on accept; 0 disables timeout.
REQ-011 SHALL have port inst_ready  input  N_CH  per-channel instance ready level.
REQ-012 SHALL have port start_inst  output  N_CH  one-cycle launch pulse per enabled channel.
REQ-013 SHALL have port ready  output  1  high iff state is IDLE.
REQ-014 SHALL have port busy  output  1  high iff state is LAUNCH, SETTLE or WAIT.
REQ-015 SHALL have port done  output  1  one-cycle pulse on successful completion of all rounds.
REQ-016 SHALL have port err  output  1  sticky timeout/abort flag; cleared on next accepted start.
REQ-017 SHALL have port tmo_mask  output  N_CH  enabled channels not done at timeout; cleared on next accepted start.
REQ-018 SHALL have port round_idx  output  ROUND_W  index of current round, 0-based.
REQ-019 SHALL have port ch_done  output  N_CH  sticky per-channel done flags for the current round.

Function
REQ-020 SHALL implement states IDLE, LAUNCH, SETTLE, WAIT, FIN; state register is only sequential element driving transitions.
REQ-021 IDLE: start=1 and abort=0 at edge -> latch ch_mask, rounds, tmo_limit; clear err, tmo_mask, round_idx, ch_done; go LAUNCH.
REQ-022 IDLE: start=1 with latched-to-be mask ch_mask==0 -> go FIN directly, no start_inst pulse.
REQ-023 LAUNCH lasts exactly 1 cycle: start_inst = latched mask; ch_done cleared; timeout counter cleared; next SETTLE.
REQ-024 SETTLE lasts exactly 1 cycle: inst_ready ignored; next WAIT.
REQ-025 WAIT: each cycle, ch_done[i] set when inst_ready[i]=1 and mask[i]=1; flags sticky until next LAUNCH.
REQ-026 WAIT: all-done condition = (ch_done | (inst_ready & mask)) covers mask, evaluated same cycle.
REQ-027 WAIT all-done and round_idx == effective_rounds-1 -> FIN; otherwise round_idx+1 and -> LAUNCH.
REQ-028 WAIT timeout counter increments each WAIT cycle, saturating; first WAIT cycle counts as 1.
REQ-029 WAIT with tmo_limit!=0, counter==tmo_limit and not all-done -> set err, tmo_mask = mask & ~done-condition, go IDLE; no done pulse.
REQ-030 All-done and timeout in same cycle -> completion wins.
REQ-031 abort=1 in LAUNCH, SETTLE or WAIT -> go IDLE next edge, set err, tmo_mask stays 0; abort in LAUNCH does not suppress that cycle's start_inst.
REQ-032 abort=1 in IDLE -> start ignored that cycle; no other effect.
REQ-033 FIN lasts 1 cycle: done=1; next IDLE; abort ignored in FIN.
REQ-034 Latency, start edge to first start_inst: 1 cycle; minimal single round with instant ready: done 4 cycles after start edge.
REQ-035 Input changes on ch_mask, rounds, tmo_limit during a run SHALL have no effect.

Reset
REQ-036 rst=1 SHALL force IDLE immediately: ready=1; start_inst, busy, done, err, tmo_mask, round_idx, ch_done, counters = 0.
REQ-037 rst asserted mid-run SHALL discard the run with no done pulse; operation resumes from IDLE after release.

Verification
REQ-038 N_CH=4, mask=4'b1011, rounds=1, tmo=0, ready channels high 2 cycles after launch -> start_inst=1011 once, done pulse, err=0.
REQ-039 rounds=3, mask=4'b1111, ready staggered per channel -> three start_inst pulses, round_idx 0,1,2, single done after round 2.
REQ-040 tmo=5, mask=4'b0110, ch2 never ready -> err=1, tmo_mask=4'b0100 after 5th WAIT cycle, no done, ready=1.
REQ-041 abort during WAIT of round 1 of rounds=4 -> IDLE next cycle, err=1, no done; next start clears err.
REQ-042 start with ch_mask=0 -> no start_inst, done pulse one cycle later; start with rounds=0 -> behaves as rounds=1.
REQ-043 rst pulse during SETTLE -> all outputs reset immediately; subsequent start completes normally.
